// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, ALU operation set and decode helper for the
// single-cycle core.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JAL      = 7'h6f;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0f;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [2:0] F3_JALR = 3'd0;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  // alt selects SUB/SRA; the caller decides when funct7[5] is meaningful.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_imem.sv
// Word-addressed instruction memory with combinational read. The load port
// lets a host fill it; the core ties it off and relies on preloading.
module rv32i_imem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [31:0]   instr,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data
);

  logic [31:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  assign instr = mem[addr];

endmodule

// File: rtl/rv32i_reg_file.sv
// 32 x XLEN register file: two combinational read ports, one synchronous
// write port, asynchronous clear. x0 is never written and always reads zero.
module rv32i_reg_file
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] reg_file1 [0:31];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) reg_file1[i] <= '0;
    end else if (we && rd_addr != 5'd0) begin
      reg_file1[rd_addr] <= rd_data;
    end
  end

  // Reads see the pre-edge value, so read-during-write returns old data.
  assign rs1_data = (rs1_addr == 5'd0) ? '0 : reg_file1[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : reg_file1[rs2_addr];

endmodule

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: fetch, decode, ALU, branch, data memory and
// writeback all settle within one clock; one instruction retires per edge.
module rv32i_core
  import rv32i_pkg::*;
#(
  parameter int          IMEM_DEPTH = 1024,
  parameter int          DMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic reset_n
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [XLEN-1:0] pc_reg, pc_next, pc_plus4;
  logic [31:0]     instr;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_data, rs2_data, wb_data;
  logic [XLEN-1:0] alu_a, alu_b, alu_y;
  logic [XLEN-1:0] br_target, jal_target, jalr_target;
  alu_op_e         alu_op;
  wb_sel_e         wb_sel;
  logic            reg_we, mem_we, br_taken;
  logic            load_ok, store_ok, imm_ok, op_ok, imm_alt;

  // reset_n is active-high despite its name.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) pc_reg <= RESET_PC;
    else         pc_reg <= pc_next;
  end

  rv32i_imem #(.DEPTH(IMEM_DEPTH), .AW(IAW)) instruction_mem (
    .clk       (clk),
    .addr      (pc_reg[IAW+1:2]),
    .instr     (instr),
    .load_en   (1'b0),
    .load_addr ('0),
    .load_data ('0)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  rv32i_reg_file i_reg_file (
    .clk      (clk),
    .rst      (reset_n),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (reg_we),
    .rd_addr  (rd),
    .rd_data  (wb_data)
  );

  assign pc_plus4    = pc_reg + 32'd4;
  assign br_target   = pc_reg + imm_b;
  assign jal_target  = pc_reg + imm_j;
  assign jalr_target = rs1_data + imm_i;

  assign load_ok  = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                    (funct3 == F3_LBU) || (funct3 == F3_LHU);
  assign store_ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
  assign imm_alt  = (funct3 == F3_SR) && funct7[5];
  assign imm_ok   = (funct3 == F3_SLL) ? (funct7 == F7_BASE) :
                    (funct3 == F3_SR)  ? (funct7 == F7_BASE || funct7 == F7_ALT) : 1'b1;
  assign op_ok    = (funct7 == F7_BASE) ||
                    (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR));

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rs1_data == rs2_data);
      F3_BNE:  br_taken = (rs1_data != rs2_data);
      F3_BLT:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: br_taken = (rs1_data <  rs2_data);
      F3_BGEU: br_taken = (rs1_data >= rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  // Main decode; anything not matched below falls through as a NOP.
  always_comb begin
    alu_op  = ALU_ADD;
    alu_a   = rs1_data;
    alu_b   = imm_i;
    reg_we  = 1'b0;
    wb_sel  = WB_ALU;
    mem_we  = 1'b0;
    pc_next = pc_plus4;
    case (opcode)
      OPC_LUI: begin
        alu_a  = '0;
        alu_b  = imm_u;
        reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        alu_a  = pc_reg;
        alu_b  = imm_u;
        reg_we = 1'b1;
      end
      OPC_JAL: begin
        reg_we  = 1'b1;
        wb_sel  = WB_PC4;
        pc_next = jal_target;
      end
      OPC_JALR: begin
        if (funct3 == F3_JALR) begin
          reg_we  = 1'b1;
          wb_sel  = WB_PC4;
          pc_next = jalr_target & ~32'd1;
        end
      end
      OPC_BRANCH: begin
        if (br_taken) pc_next = br_target;
      end
      OPC_LOAD: begin
        reg_we = load_ok;
        wb_sel = WB_MEM;
      end
      OPC_STORE: begin
        alu_b  = imm_s;
        mem_we = store_ok;
      end
      OPC_OP_IMM: begin
        alu_op = alu_decode(funct3, imm_alt);
        reg_we = imm_ok;
      end
      OPC_OP: begin
        alu_b  = rs2_data;
        alu_op = alu_decode(funct3, funct7[5]);
        reg_we = op_ok;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD:  alu_y = alu_a + alu_b;
      ALU_SUB:  alu_y = alu_a - alu_b;
      ALU_SLL:  alu_y = alu_a << alu_b[4:0];
      ALU_SLT:  alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'b0, alu_a < alu_b};
      ALU_XOR:  alu_y = alu_a ^ alu_b;
      ALU_SRL:  alu_y = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      ALU_OR:   alu_y = alu_a | alu_b;
      ALU_AND:  alu_y = alu_a & alu_b;
      default:  alu_y = '0;
    endcase
  end

  // Data memory: word array, byte-lane writes on the retiring edge.
  logic [31:0]    dmem [0:DMEM_DEPTH-1];
  logic [DAW-1:0] dmem_idx;
  logic [31:0]    dmem_rdata, dmem_wdata, load_data;
  logic [3:0]     dmem_be;
  logic [7:0]     load_byte;
  logic [15:0]    load_half;

  assign dmem_idx   = alu_y[DAW+1:2];
  assign dmem_rdata = dmem[dmem_idx];
  assign load_half  = alu_y[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_byte = dmem_rdata[7:0];
    case (alu_y[1:0])
      2'd1:    load_byte = dmem_rdata[15:8];
      2'd2:    load_byte = dmem_rdata[23:16];
      2'd3:    load_byte = dmem_rdata[31:24];
      default: load_byte = dmem_rdata[7:0];
    endcase
  end

  always_comb begin
    load_data = dmem_rdata;
    case (funct3)
      F3_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      F3_LH:   load_data = {{16{load_half[15]}}, load_half};
      F3_LBU:  load_data = {24'b0, load_byte};
      F3_LHU:  load_data = {16'b0, load_half};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = rs2_data;
    case (funct3)
      F3_SB: begin
        dmem_be    = 4'b0001 << alu_y[1:0];
        dmem_wdata = {4{rs2_data[7:0]}};
      end
      F3_SH: begin
        dmem_be    = alu_y[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{rs2_data[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = rs2_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_be[b]) dmem[dmem_idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    wb_data = alu_y;
    case (wb_sel)
      WB_MEM:  wb_data = load_data;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_y;
    endcase
  end

endmodule

// File: tb/tb_rv32i_core.sv
// Directed bench for rv32i_core: hand-assembled programs, hand-computed
// register/PC results, reset hold, mid-run asynchronous reset.
module tb_rv32i_core;

  logic clk = 1'b1;
  logic reset_n;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   wr_idx;

  rv32i_core dut (
    .clk     (clk),
    .reset_n (reset_n)
  );

  // Rising edges at 10, 20, 30 ...; 35 ns falls between edges.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%08h expected=%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %08h", tag, got);
    end
  endtask

  function automatic logic [31:0] rf(input int i);
    return dut.i_reg_file.reg_file1[i];
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return enc_i(imm, rs1, 3'd0, rd, 7'h13);
  endfunction

  task automatic emit(input logic [31:0] w);
    dut.instruction_mem.mem[wr_idx] = w;
    wr_idx++;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) dut.instruction_mem.mem[i] = 32'h0;
    wr_idx = 0;
  endtask

  task automatic load_prog_a();
    clear_imem();
    emit(addi(5, 0, 12'd5));                   // 00
    emit(addi(6, 0, 12'd6));                   // 04
    emit(enc_r(7'h00, 6, 5, 3'd0, 7));         // 08 add x7,x5,x6
    emit(enc_r(7'h20, 6, 5, 3'd0, 8));         // 0C sub x8,x5,x6
    emit(addi(0, 0, 12'd1));                   // 10
    emit({20'h12345, 5'd1, 7'h37});            // 14 lui x1
    emit(addi(1, 1, 12'h678));                 // 18
    emit(enc_i(12'h404, 8, 3'd5, 2, 7'h13));   // 1C srai x2,x8,4
    emit({20'h00001, 5'd4, 7'h17});            // 20 auipc x4,1
    emit(enc_i(12'd28, 8, 3'd5, 3, 7'h13));    // 24 srli x3,x8,28
    emit(addi(10, 0, 12'h100));                // 28
    emit(enc_s(12'd0, 1, 10, 3'd2));           // 2C sw x1,0(x10)
    emit(enc_s(12'd1, 0, 10, 3'd0));           // 30 sb x0,1(x10)
    emit(enc_i(12'd0, 10, 3'd2, 11, 7'h03));   // 34 lw x11
    emit(enc_i(12'd3, 10, 3'd0, 12, 7'h03));   // 38 lb x12
    emit(enc_i(12'd2, 10, 3'd1, 13, 7'h03));   // 3C lh x13
    emit(enc_s(12'd4, 8, 10, 3'd0));           // 40 sb x8,4(x10)
    emit(enc_i(12'd4, 10, 3'd0, 14, 7'h03));   // 44 lb x14
    emit(enc_i(12'd4, 10, 3'd4, 15, 7'h03));   // 48 lbu x15
    emit(enc_s(12'd6, 8, 10, 3'd1));           // 4C sh x8,6(x10)
    emit(enc_i(12'd6, 10, 3'd5, 16, 7'h03));   // 50 lhu x16
    emit(enc_r(7'h00, 5, 8, 3'd2, 17));        // 54 slt x17,x8,x5
    emit(enc_r(7'h00, 5, 8, 3'd3, 18));        // 58 sltu x18,x8,x5
    emit(enc_r(7'h00, 6, 5, 3'd4, 19));        // 5C xor
    emit(enc_r(7'h00, 6, 5, 3'd6, 20));        // 60 or
    emit(enc_r(7'h00, 6, 5, 3'd7, 21));        // 64 and
    emit(enc_r(7'h00, 6, 5, 3'd1, 22));        // 68 sll x22,x5,x6
    emit(enc_r(7'h00, 5, 8, 3'd5, 23));        // 6C srl x23,x8,x5
    emit(enc_i(12'd6, 5, 3'd3, 24, 7'h13));    // 70 sltiu x24,x5,6
    emit(enc_i(12'hFFF, 5, 3'd4, 25, 7'h13));  // 74 xori x25,x5,-1
    emit(enc_i(12'd31, 5, 3'd1, 26, 7'h13));   // 78 slli x26,x5,31
    emit(32'h0000_0073);                       // 7C ecall
    emit(enc_r(7'h01, 6, 5, 3'd0, 28));        // 80 unsupported funct7
    emit(addi(29, 0, 12'h7FF));                // 84
    emit(enc_r(7'h20, 5, 26, 3'd5, 30));       // 88 sra x30,x26,x5
  endtask

  task automatic load_prog_b();
    clear_imem();
    emit(addi(5, 0, 12'd5));                   // 00
    emit(addi(6, 0, 12'd6));                   // 04
    emit(enc_b(13'd8, 6, 5, 3'd1));            // 08 bne -> 10
    emit(addi(7, 0, 12'd1));                   // 0C skipped
    emit(addi(5, 0, 12'hFFF));                 // 10 x5=-1
    emit(addi(6, 0, 12'd1));                   // 14
    emit(enc_b(13'd8, 6, 5, 3'd4));            // 18 blt taken -> 20
    emit(addi(9, 0, 12'd1));                   // 1C skipped
    emit(enc_b(13'd8, 6, 5, 3'd6));            // 20 bltu not taken
    emit(addi(10, 0, 12'd1));                  // 24
    emit(enc_b(13'd24, 0, 0, 3'd0));           // 28 beq -> 40
    wr_idx = 16;
    emit(enc_j(21'd12, 1));                    // 40 jal x1,+12
    emit(addi(11, 0, 12'd7));                  // 44
    emit(enc_j(21'd0, 0));                     // 48 self loop
    emit(addi(12, 0, 12'd3));                  // 4C
    emit(enc_i(12'd1, 1, 3'd0, 0, 7'h67));     // 50 jalr x0,1(x1)
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_prog_b_final(input string pfx);
    check_eq({pfx, "_pc_loop"}, dut.pc_reg, 32'h48);
    check_eq({pfx, "_x1_link"}, rf(1), 32'h44);
    check_eq({pfx, "_x5"}, rf(5), 32'hFFFF_FFFF);
    check_eq({pfx, "_x7_bne_skip"}, rf(7), 32'h0);
    check_eq({pfx, "_x9_blt_skip"}, rf(9), 32'h0);
    check_eq({pfx, "_x10_bltu_nt"}, rf(10), 32'h1);
    check_eq({pfx, "_x11_after_ret"}, rf(11), 32'h7);
    check_eq({pfx, "_x12_jal_tgt"}, rf(12), 32'h3);
  endtask

  initial begin
    reset_n = 1'b1;
    load_prog_a();
    #35;
    check_eq("rst_pc", dut.pc_reg, 32'h0);
    for (int i = 0; i < 32; i++) check_eq($sformatf("rst_x%0d", i), rf(i), 32'h0);
    reset_n = 1'b0;
    #1;
    check_eq("rel_pc_before_edge", dut.pc_reg, 32'h0);
    run_cycles(1);
    check_eq("first_pc", dut.pc_reg, 32'h4);
    check_eq("first_x5", rf(5), 32'h5);
    run_cycles(34);
    check_eq("a_pc", dut.pc_reg, 32'h8C);
    check_eq("add_x7", rf(7), 32'h0000_000B);
    check_eq("sub_x8", rf(8), 32'hFFFF_FFFF);
    check_eq("x0_zero", rf(0), 32'h0);
    check_eq("lui_addi_x1", rf(1), 32'h1234_5678);
    check_eq("srai_x2", rf(2), 32'hFFFF_FFFF);
    check_eq("srli_x3", rf(3), 32'h0000_000F);
    check_eq("auipc_x4", rf(4), 32'h0000_1020);
    check_eq("lw_x11", rf(11), 32'h1234_0078);
    check_eq("lb_x12", rf(12), 32'h0000_0012);
    check_eq("lh_x13", rf(13), 32'h0000_1234);
    check_eq("lb_neg_x14", rf(14), 32'hFFFF_FFFF);
    check_eq("lbu_x15", rf(15), 32'h0000_00FF);
    check_eq("lhu_x16", rf(16), 32'h0000_FFFF);
    check_eq("slt_x17", rf(17), 32'h1);
    check_eq("sltu_x18", rf(18), 32'h0);
    check_eq("xor_x19", rf(19), 32'h3);
    check_eq("or_x20", rf(20), 32'h7);
    check_eq("and_x21", rf(21), 32'h4);
    check_eq("sll_x22", rf(22), 32'h140);
    check_eq("srl_x23", rf(23), 32'h07FF_FFFF);
    check_eq("sltiu_x24", rf(24), 32'h1);
    check_eq("xori_x25", rf(25), 32'hFFFF_FFFA);
    check_eq("slli_x26", rf(26), 32'h8000_0000);
    check_eq("nop_x28", rf(28), 32'h0);
    check_eq("addi_x29", rf(29), 32'h0000_07FF);
    check_eq("sra_x30", rf(30), 32'hFC00_0000);

    // Control flow program, loaded under reset.
    #2;
    reset_n = 1'b1;
    load_prog_b();
    @(negedge clk);
    reset_n = 1'b0;
    run_cycles(10);
    check_eq("b_jal_pc", dut.pc_reg, 32'h4C);
    check_eq("b_jal_x1", rf(1), 32'h44);
    run_cycles(2);
    check_eq("b_jalr_pc", dut.pc_reg, 32'h44);
    run_cycles(8);
    check_prog_b_final("b");

    // Asynchronous reset between edges while spinning in the loop.
    #2;
    reset_n = 1'b1;
    #1;
    check_eq("mid_rst_pc", dut.pc_reg, 32'h0);
    check_eq("mid_rst_x1", rf(1), 32'h0);
    check_eq("mid_rst_x5", rf(5), 32'h0);
    check_eq("mid_rst_x11", rf(11), 32'h0);
    @(negedge clk);
    reset_n = 1'b0;
    run_cycles(20);
    check_prog_b_final("rerun");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
